irobot_uart_rx: RTL

IROBOT_UART_RX -- requirements
Module: irobot_uart_rx

---
 rtl/irobot_uart_rx_pkg.sv | 22 ++
 rtl/irobot_uart_rx_fifo.sv | 60 ++++++
 rtl/irobot_uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/irobot_uart_rx_pkg.sv
// Shared definitions for the iRobot Create serial link.
// Receiver FSM states and default link timing.
package irobot_uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
    localparam int unsigned DEFAULT_BAUD   = 57600;

    function automatic int unsigned bit_cycles(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/irobot_uart_rx_fifo.sv
// Show-ahead byte FIFO for received UART data.
// Push into a full FIFO is dropped unless a pop happens on the same edge.
module rx_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign count  = r_count;
    assign head   = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/irobot_uart_rx.sv
// 8N1 receiver for the iRobot Create serial link.
// Mid-bit sampling FSM feeding a small show-ahead byte FIFO.
module irobot_uart_rx
    import irobot_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RxD,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int unsigned BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int          CW          = $clog2(BIT_CYCLES);

    rx_state_t    r_state;
    rx_state_t    w_state_nx;
    logic         r_sync1;
    logic         r_rxs;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]   r_idx;
    logic [2:0]   w_idx_nx;
    logic [7:0]   r_shift;
    logic [7:0]   w_shift_nx;
    logic         w_push;
    logic         w_ferr;
    logic         w_full;
    logic         w_empty;
    logic         r_frame_err;
    logic         r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (!r_rxs) begin
                    w_state_nx = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (r_cnt == CW'(HALF_CYCLES - 1)) begin
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_state_nx = r_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CW'(BIT_CYCLES - 1)) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = {r_rxs, r_shift[7:1]};
                    w_idx_nx   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == CW'(BIT_CYCLES - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                    w_push     = r_rxs;
                    w_ferr     = !r_rxs;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    // When full the FIFO is non-empty, so rx_ready alone decides the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overflow  <= w_push && w_full && !rx_ready;
        end
    end

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE);

endmodule
